// File: rtl/stream_pkg.sv
// Shared types, default widths and the select-width helper for the stream demux.
package stream_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_N_OUT  = 4;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } demux_state_e;

  // A two-way demux still needs one select bit, so never return less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/out_reg_slice.sv
// Single-entry valid/ready output register holding {data, last, dest}.
module out_reg_slice
  import stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_OUT  = DEF_N_OUT,
  parameter int unsigned SEL_W  = clog2_min1(N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [SEL_W-1:0]  in_dest,
  input  logic [N_OUT-1:0]  out_ready,
  output logic              ready_c,
  output logic [N_OUT-1:0]  out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [SEL_W-1:0]  dest
);

  logic drain_c;

  // Valid is kept one-hot so only the selected channel's ready matters.
  assign drain_c = |(out_valid & out_ready);
  assign ready_c = ~|(out_valid & ~out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      dest      <= '0;
    end else if (load) begin
      out_valid <= N_OUT'(1) << in_dest;
      out_data  <= in_data;
      out_last  <= in_last;
      dest      <= in_dest;
    end else if (drain_c) begin
      out_valid <= '0;
    end
  end

endmodule

// File: rtl/stream_demux_1_n.sv
// 1-to-N packet-locked stream demux with a registered output and invalid-select dropping.
module stream_demux_1_n
  import stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_OUT  = DEF_N_OUT,
  parameter int unsigned SEL_W  = clog2_min1(N_OUT),
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_last,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err_sel,
  output logic [CNT_W-1:0]  drop_cnt
);

  demux_state_e     state;
  logic             slice_ready_c;
  logic             accept_c;
  logic             sel_ok_c;
  logic             load_c;
  logic [SEL_W-1:0] dest_r;
  logic [SEL_W-1:0] load_dest_c;

  assign in_ready    = (state == DROP) | slice_ready_c;
  assign accept_c    = in_valid & in_ready;
  assign sel_ok_c    = (32'(in_sel) < N_OUT);
  assign load_c      = accept_c & (((state == IDLE) & sel_ok_c) | (state == PKT));
  // Mid-packet beats follow the destination latched on the first beat.
  assign load_dest_c = (state == PKT) ? dest_r : in_sel;

  out_reg_slice #(
    .DATA_W (DATA_W),
    .N_OUT  (N_OUT),
    .SEL_W  (SEL_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_dest   (load_dest_c),
    .out_ready (out_ready),
    .ready_c   (slice_ready_c),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .dest      (dest_r)
  );

  // Packet framing FSM, drop pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_sel <= 1'b0;
      if (accept_c) begin
        case (state)
          IDLE: begin
            if (sel_ok_c) begin
              state <= in_last ? IDLE : PKT;
            end else begin
              err_sel <= 1'b1;
              if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
              end
              state <= in_last ? IDLE : DROP;
            end
          end
          PKT, DROP: begin
            if (in_last) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
